// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline types for the fetch/data memory port arbiter.
// Holds the FSM state encoding, the owner encoding and the starvation counter width.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_D  = 1'b1
  } arb_owner_e;

  // Wide enough for the largest legal starvation limit (15).
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of consecutive arbitrations that fetch requested but lost.
// Clear has priority over increment.
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != LIMIT_V)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign at_limit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between fetch reads and data loads/stores.
// Define RISKY_ARB_ROUND_ROBIN_EN to replace the starvation guard with tie alternation.
// Handshake: a requester holds req and its fields stable until its gnt pulses;
// gnt = mem_req_o & mem_ready_i & owner match; rvalid pulses only in RESP.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [ADDR_W-1:0]   d_addr_i,
  input  logic [DATA_W-1:0]   d_wdata_i,
  input  logic [DATA_W/8-1:0] d_be_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DATA_W-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic                mem_ready_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                busy_o,
  output arb_state_e          dbg_state
);

  arb_state_e state_q, state_d;
  arb_owner_e owner_q;

  logic rd_accept, wr_accept, arb_pt;
  logic if_req_eff, d_req_eff, any_req, if_wins, launch;

  assign rd_accept = (state_q == ARB_REQ) && mem_ready_i && !mem_we_o;
  assign wr_accept = (state_q == ARB_REQ) && mem_ready_i &&  mem_we_o;
  assign arb_pt    = (state_q == ARB_IDLE)
                   || ((state_q == ARB_RESP) && mem_rvalid_i)
                   || wr_accept;

  // The store being granted this cycle is still on d_req_i; it must not be issued twice.
  assign if_req_eff = if_req_i;
  assign d_req_eff  = d_req_i && !wr_accept;
  assign any_req    = if_req_eff || d_req_eff;
  assign launch     = arb_pt && any_req;

`ifdef RISKY_ARB_ROUND_ROBIN_EN
  logic last_d_won_q;

  assign if_wins = if_req_eff && (!d_req_eff || last_d_won_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_won_q <= 1'b1;
    end else if (arb_pt && if_req_eff && d_req_eff) begin
      last_d_won_q <= !if_wins;
    end
  end
`else
  logic starve_hit;

  assign if_wins = if_req_eff && (!d_req_eff || starve_hit);

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (arb_pt && if_req_eff && !if_wins),
    .clr      (arb_pt && (!if_req_eff || if_wins)),
    .at_limit (starve_hit)
  );
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (any_req) state_d = ARB_REQ;
      ARB_REQ: begin
        if (rd_accept)      state_d = ARB_RESP;
        else if (wr_accept) state_d = any_req ? ARB_REQ : ARB_IDLE;
      end
      ARB_RESP: if (mem_rvalid_i) state_d = any_req ? ARB_REQ : ARB_IDLE;
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWNER_IF;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
    end else begin
      state_q   <= state_d;
      mem_req_o <= (state_d == ARB_REQ);
      if (launch) begin
        if (if_wins) begin
          owner_q     <= OWNER_IF;
          mem_we_o    <= 1'b0;
          mem_addr_o  <= if_addr_i;
          mem_wdata_o <= '0;
          mem_be_o    <= '1;
        end else begin
          owner_q     <= OWNER_D;
          mem_we_o    <= d_we_i;
          mem_addr_o  <= d_addr_i;
          mem_wdata_o <= d_wdata_i;
          mem_be_o    <= d_be_i;
        end
      end
    end
  end

  assign if_gnt_o    = mem_req_o && mem_ready_i && (owner_q == OWNER_IF);
  assign d_gnt_o     = mem_req_o && mem_ready_i && (owner_q == OWNER_D);
  assign if_rvalid_o = (state_q == ARB_RESP) && mem_rvalid_i && (owner_q == OWNER_IF);
  assign d_rvalid_o  = (state_q == ARB_RESP) && mem_rvalid_i && (owner_q == OWNER_D);
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;
  assign busy_o      = (state_q != ARB_IDLE);
  assign dbg_state   = state_q;

endmodule
